// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with Moore-style decoded control outputs.
// Define MULTI_CYCLE_CTRL_MEM_WAIT_EN to make IF and MEM stall on mem_ready; otherwise mem_ready is ignored.
module multi_cycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ins,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_wr,
   output logic [1:0]  pc_src,
   output logic        ir_wr,
   output logic        i_or_d,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        reg_dst,
   output logic        reg_wr,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_ctr,
   output logic        instr_done,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   state_t     state_q, state_d;
   logic [5:0] op;
   logic [5:0] func;
   logic       r_ok;
   logic [3:0] r_ctr;
   logic       op_ok;
   logic       mem_go;
   logic       unused_bits;

   assign op          = ins[31:26];
   assign func        = ins[5:0];
   assign unused_bits = ^ins[25:6];

`ifdef MULTI_CYCLE_CTRL_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_go           = 1'b1;
`endif

   always_comb begin
      r_ok  = 1'b1;
      r_ctr = 4'b0000;
      case (func)
         6'h21:   r_ctr = 4'b0000;
         6'h20:   r_ctr = 4'b0001;
         6'h23:   r_ctr = 4'b1000;
         6'h22:   r_ctr = 4'b1001;
         6'h24:   r_ctr = 4'b0010;
         6'h25:   r_ctr = 4'b0011;
         6'h2B:   r_ctr = 4'b1010;
         6'h2A:   r_ctr = 4'b1011;
         default: r_ok  = 1'b0;
      endcase
   end

   assign op_ok = ((op == OP_R) && r_ok) || (op == OP_LW) || (op == OP_SW) ||
                  (op == OP_BEQ) || (op == OP_J);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   // Reset gates every output combinationally, so the strobes drop in the same cycle rst rises.
   always_comb begin
      state_d    = S_IF;
      pc_wr      = 1'b0;
      pc_src     = 2'b00;
      ir_wr      = 1'b0;
      i_or_d     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_dst    = 1'b0;
      reg_wr     = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctr    = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IF: begin
               mem_rd    = 1'b1;
               alu_src_b = 2'b01;
               if (mem_go) begin
                  ir_wr   = 1'b1;
                  pc_wr   = 1'b1;
                  state_d = S_ID;
               end else begin
                  state_d = S_IF;
               end
            end
            S_ID: begin
               alu_src_b = 2'b11;
               if (!op_ok) begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end else if (op == OP_J) begin
                  pc_wr      = 1'b1;
                  pc_src     = 2'b10;
                  instr_done = 1'b1;
               end else begin
                  state_d = S_EX;
               end
            end
            S_EX: begin
               alu_src_a = 1'b1;
               if (op == OP_R) begin
                  alu_ctr = r_ctr;
                  state_d = S_WB;
               end else if ((op == OP_LW) || (op == OP_SW)) begin
                  alu_src_b = 2'b10;
                  alu_ctr   = 4'b0001;
                  state_d   = S_MEM;
               end else if (op == OP_BEQ) begin
                  alu_ctr    = 4'b1000;
                  pc_src     = 2'b01;
                  pc_wr      = zero;
                  instr_done = 1'b1;
               end
            end
            S_MEM: begin
               i_or_d = 1'b1;
               if (op == OP_LW) begin
                  mem_rd  = 1'b1;
                  state_d = mem_go ? S_WB : S_MEM;
               end else if (op == OP_SW) begin
                  mem_wr     = 1'b1;
                  instr_done = mem_go;
                  state_d    = mem_go ? S_IF : S_MEM;
               end
            end
            S_WB: begin
               reg_wr     = 1'b1;
               instr_done = 1'b1;
               if (op == OP_LW) mem_to_reg = 1'b1;
               else             reg_dst    = 1'b1;
            end
            default: state_d = S_IF;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: every cycle compares the full packed output vector against a hand-built value.
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        zero;
   logic        mem_ready;
   logic        pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst, reg_wr, mem_to_reg;
   logic        alu_src_a, instr_done, illegal;
   logic [1:0]  pc_src, alu_src_b;
   logic [3:0]  alu_ctr;
   logic [2:0]  state;
   logic [21:0] obs;

   int total = 0;
   int bad   = 0;

   multi_cycle_ctrl dut (
      .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .i_or_d(i_or_d),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_dst(reg_dst), .reg_wr(reg_wr),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctr(alu_ctr), .instr_done(instr_done), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst, reg_wr, mem_to_reg,
                 alu_src_a, alu_src_b, alu_ctr, instr_done, illegal, state};

   function automatic logic [21:0] pk(
      input logic pw, input logic [1:0] ps, input logic iw, input logic iod,
      input logic mr, input logic mw, input logic rd, input logic rw, input logic m2r,
      input logic a, input logic [1:0] b, input logic [3:0] ctr,
      input logic done, input logic ill, input logic [2:0] st);
      return {pw, ps, iw, iod, mr, mw, rd, rw, m2r, a, b, ctr, done, ill, st};
   endfunction

   localparam logic [21:0] ZERO     = 22'd0;
   localparam logic [21:0] IF_GO    = pk(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0000, 0, 0, 3'd0);
   localparam logic [21:0] IF_WAIT  = pk(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0000, 0, 0, 3'd0);
   localparam logic [21:0] ID_NORM  = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 3'd1);
   localparam logic [21:0] ID_J     = pk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 0, 3'd1);
   localparam logic [21:0] ID_ILL   = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 1, 3'd1);
   localparam logic [21:0] EX_MEMOP = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0001, 0, 0, 3'd2);
   localparam logic [21:0] EX_BEQ1  = pk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b1000, 1, 0, 3'd2);
   localparam logic [21:0] EX_BEQ0  = pk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b1000, 1, 0, 3'd2);
   localparam logic [21:0] MEM_LW   = pk(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 3'd3);
   localparam logic [21:0] MEM_SWW  = pk(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 3'd3);
   localparam logic [21:0] MEM_SWG  = pk(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 0, 3'd3);
   localparam logic [21:0] WB_R     = pk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, 1, 0, 3'd4);
   localparam logic [21:0] WB_LW    = pk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0000, 1, 0, 3'd4);

`ifdef MULTI_CYCLE_CTRL_MEM_WAIT_EN
   localparam logic [21:0] IF_STALL  = IF_WAIT;
   localparam logic [21:0] MEM_STALL = MEM_SWW;
`else
   localparam logic [21:0] IF_STALL  = IF_GO;
   localparam logic [21:0] MEM_STALL = MEM_SWG;
`endif

   localparam logic [31:0] I_LW  = 32'h8C220004;
   localparam logic [31:0] I_SW  = 32'hAC220004;
   localparam logic [31:0] I_BEQ = 32'h10220003;

   task automatic chk(input string tag, input logic [21:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
      end
      $display("t=%0t %s ins=%08h state=%0d obs=%06h exp=%06h", $time, tag, ins, state, obs, exp);
   endtask

   // Apply inputs mid-cycle, check the decode, then let one rising edge pass.
   task automatic step(input string tag, input logic [31:0] i, input logic mr, input logic z,
                       input logic [21:0] exp);
      ins       = i;
      mem_ready = mr;
      zero      = z;
      #1;
      chk(tag, exp);
      @(negedge clk);
   endtask

   logic [5:0] funcs [8] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h2B, 6'h2A};
   logic [3:0] ctrs  [8] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0010, 4'b0011, 4'b1010, 4'b1011};

   initial begin
      rst       = 1'b1;
      ins       = I_SW;
      zero      = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      #1 chk("rst_hold0", ZERO);
      @(negedge clk);
      #1 chk("rst_hold1", ZERO);
      @(negedge clk);
      rst = 1'b0;

      // R-type: addu first (0x00221821), then the other seven funcs
      for (int k = 0; k < 8; k++) begin
         logic [31:0] ri;
         ri = {26'h0008860, funcs[k]};
         step("r_if", ri, 1'b1, 1'b0, IF_GO);
         step("r_id", ri, 1'b1, 1'b0, ID_NORM);
         step("r_ex", ri, 1'b1, 1'b0, pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ctrs[k], 0, 0, 3'd2));
         step("r_wb", ri, 1'b1, 1'b0, WB_R);
      end

      step("lw_if",  I_LW, 1'b1, 1'b0, IF_GO);
      step("lw_id",  I_LW, 1'b1, 1'b0, ID_NORM);
      step("lw_ex",  I_LW, 1'b1, 1'b0, EX_MEMOP);
      step("lw_mem", I_LW, 1'b1, 1'b0, MEM_LW);
      step("lw_wb",  I_LW, 1'b1, 1'b0, WB_LW);

      step("sw_if", I_SW, 1'b1, 1'b0, IF_GO);
      step("sw_id", I_SW, 1'b1, 1'b0, ID_NORM);
      step("sw_ex", I_SW, 1'b1, 1'b0, EX_MEMOP);
`ifdef MULTI_CYCLE_CTRL_MEM_WAIT_EN
      step("sw_mem_w0", I_SW, 1'b0, 1'b0, MEM_SWW);
      step("sw_mem_w1", I_SW, 1'b0, 1'b0, MEM_SWW);
      step("sw_mem_w2", I_SW, 1'b0, 1'b0, MEM_SWW);
      step("sw_mem_go", I_SW, 1'b1, 1'b0, MEM_SWG);
`else
      step("sw_mem_one", I_SW, 1'b0, 1'b0, MEM_SWG);
`endif

      // fetch stall on the next instruction, then beq taken
      step("beq1_if_stall", I_BEQ, 1'b0, 1'b1, IF_STALL);
`ifdef MULTI_CYCLE_CTRL_MEM_WAIT_EN
      step("beq1_if", I_BEQ, 1'b1, 1'b1, IF_GO);
`endif
      step("beq1_id", I_BEQ, 1'b1, 1'b1, ID_NORM);
      step("beq1_ex", I_BEQ, 1'b1, 1'b1, EX_BEQ1);
      step("beq0_if", I_BEQ, 1'b1, 1'b0, IF_GO);
      step("beq0_id", I_BEQ, 1'b1, 1'b0, ID_NORM);
      step("beq0_ex", I_BEQ, 1'b1, 1'b0, EX_BEQ0);

      step("j_if", 32'h08000010, 1'b1, 1'b0, IF_GO);
      step("j_id", 32'h08000010, 1'b1, 1'b0, ID_J);
      step("op3f_if", 32'hFC000000, 1'b1, 1'b0, IF_GO);
      step("op3f_id", 32'hFC000000, 1'b1, 1'b0, ID_ILL);
      step("func0_if", 32'h00000000, 1'b1, 1'b0, IF_GO);
      step("func0_id", 32'h00000000, 1'b1, 1'b0, ID_ILL);

      // reset raised during a stalled SW memory cycle
      step("swr_if", I_SW, 1'b1, 1'b0, IF_GO);
      step("swr_id", I_SW, 1'b1, 1'b0, ID_NORM);
      step("swr_ex", I_SW, 1'b1, 1'b0, EX_MEMOP);
      mem_ready = 1'b0;
      #1 chk("swr_mem", MEM_STALL);
      rst = 1'b1;
      #1 chk("swr_rst_now", ZERO);
      @(negedge clk);
      #1 chk("swr_rst_held", ZERO);
      rst = 1'b0;
      step("swr_refetch", I_SW, 1'b1, 1'b0, IF_GO);
      step("swr_id2", I_SW, 1'b1, 1'b0, ID_NORM);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 ins  in  32  instruction register contents; valid from ID onward; op=ins[31:26], func=ins[5:0].
REQ-004 zero  in  1  ALU zero flag from datapath.
REQ-005 mem_ready  in  1  memory completes current access this cycle.
REQ-006 pc_wr  out  1  PC write enable.
REQ-007 pc_src  out  2  PC source: 00 ALU (PC+4), 01 ALU-out register (branch target), 10 jump target.
REQ-008 ir_wr  out  1  instruction register write enable.
REQ-009 i_or_d  out  1  memory address select: 0 PC, 1 ALU-out.
REQ-010 mem_rd  out  1  memory read strobe, held until mem_ready.
REQ-011 mem_wr  out  1  memory write strobe, held until mem_ready.
REQ-012 reg_dst  out  1  register destination select: 1 rd, 0 rt.
REQ-013 reg_wr  out  1  register file write enable.
REQ-014 mem_to_reg  out  1  write-back source select: 1 memory data, 0 ALU-out.
REQ-015 alu_src_a  out  1  ALU operand A select: 0 PC, 1 rs.
REQ-016 alu_src_b  out  2  ALU operand B select: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-017 alu_ctr  out  4  ALU op: ADDU 0000, ADD 0001, SUBU 1000, SUB 1001, AND 0010, OR 0011, SLTU 1010, SLT 1011.
REQ-018 instr_done  out  1  one-cycle pulse in the final cycle of each instruction, including illegal ones.
REQ-019 illegal  out  1  one-cycle pulse in ID on unsupported op or R-type func.
REQ-020 state  out  3  current state: IF 0, ID 1, EX 2, MEM 3, WB 4.

Function
REQ-021 Outputs shall be Moore decodes of state and ins; unlisted outputs are 0; alu_ctr defaults to 0000.
REQ-022 Supported ops: R 000000 (eight funcs per REQ-017), LW 100011, SW 101011, BEQ 000100, J 000010.
REQ-023 IF: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADDU; if mem_ready, ir_wr=1, pc_wr=1, pc_src=00, next ID; else stay IF with no writes.
REQ-024 ID: alu_src_a=0, alu_src_b=11, ADDU (branch target); R/LW/SW/BEQ -> EX; J: pc_wr=1, pc_src=10, instr_done=1, -> IF; illegal: illegal=1, instr_done=1, no write enables, -> IF.
REQ-025 EX R-type: alu_src_a=1, alu_src_b=00, alu_ctr from func, -> WB.
REQ-026 EX LW/SW: alu_src_a=1, alu_src_b=10, ADD, -> MEM.
REQ-027 EX BEQ: alu_src_a=1, alu_src_b=00, SUBU, pc_src=01, pc_wr=zero, instr_done=1, -> IF.
REQ-028 MEM: i_or_d=1; LW mem_rd=1, SW mem_wr=1; hold until mem_ready; then LW -> WB, SW -> IF with instr_done=1.
REQ-029 WB: reg_wr=1; R: reg_dst=1, mem_to_reg=0; LW: reg_dst=0, mem_to_reg=1; instr_done=1, -> IF.
REQ-030 Latency with mem_ready=1: J 2, BEQ 3, R 4, SW 4, LW 5 cycles; each wait cycle adds 1.
REQ-031 Undefined state encodings 5-7 shall force all outputs 0 and return to IF next cycle.

Reset
REQ-032 rst=1 shall force state to IF immediately; while rst=1, all outputs are 0, including pc_wr, ir_wr, mem_rd, mem_wr and reg_wr.
REQ-033 Reset mid-instruction shall abandon it with no further writes; fetch restarts in the first cycle after rst deasserts.

Configuration
REQ-034 With MULTI_CYCLE_CTRL_MEM_WAIT_EN defined, IF and MEM wait on mem_ready per REQ-023/REQ-028.
REQ-035 Without MULTI_CYCLE_CTRL_MEM_WAIT_EN, mem_ready shall be ignored and treated as 1; IF and MEM each last exactly one cycle.

Verification
REQ-036 addu 0x00221821, mem_ready=1 -> states 0,1,2,4; alu_ctr=0000 in EX; reg_wr=1, reg_dst=1 in WB; instr_done in cycle 4.
REQ-037 lw 0x8C220004 -> 5 cycles; MEM: mem_rd=1, i_or_d=1; WB: mem_to_reg=1, reg_dst=0, reg_wr=1.
REQ-038 sw 0xAC220004, mem_ready low for 3 MEM cycles -> WAIT_EN: mem_wr high 4 cycles, then IF; no WAIT_EN: mem_wr high 1 cycle.
REQ-039 beq 0x10220003: zero=1 -> EX pc_wr=1, pc_src=01; zero=0 -> pc_wr=0; both return to IF after 3 cycles.
REQ-040 j 0x08000010 -> ID pc_wr=1, pc_src=10, instr_done=1; op 0x3F or R-func 0x00 -> illegal pulse, no write enables.
REQ-041 rst raised during SW MEM cycle -> mem_wr=0 same cycle, state=0; first cycle after release: mem_rd=1, i_or_d=0.
